// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream,
// assembles little-endian 32-bit words, writes them to instruction memory
// and releases the CPU from reset once the checksum has been verified.
//
// Byte handshake: a byte moves from the sender to the loader on a rising
// clock edge where rx_valid && rx_ready are both 1. rx_valid may be held
// low for any number of cycles without effect. rx_ready is registered and
// depends only on the loader state.
module prog_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_n_reset,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        cpu_n_reset_q, cpu_n_reset_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rx_ready_q, rx_ready_d;

  logic        xfer;
  logic [15:0] n_words;
  logic [15:0] word_next;
  logic [31:0] word_full;

  // Next-state and registered-output computation for the load sequence.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    xfer         = rx_valid && rx_ready_q;
    n_words      = {rx_data, len_q[7:0]};
    word_next    = word_cnt_q + 16'd1;
    word_full    = {rx_data, asm_q[31:8]};

    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d      = n_words;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
          csum_d     = 8'd0;
          if ({16'd0, n_words} > MAX_W) state_d = S_ERR;
          else if (n_words == 16'd0)    state_d = S_CSUM;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shift right so the first byte of a word ends up in bits 7:0.
          asm_d      = word_full;
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ADDR_BASE + {14'd0, word_cnt_q, 2'b00};
            imem_wdata_d = word_full;
            word_cnt_d   = word_next;
            if (word_next == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
      end
      default: ;
    endcase

    rx_ready_d    = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                    (state_d == S_DATA) || (state_d == S_CSUM);
    done_d        = (state_d == S_RUN);
    cpu_n_reset_d = (state_d == S_RUN);
    err_d         = (state_d == S_ERR);
  end

  // State and registered outputs; synchronous reset aborts any load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LEN0;
      len_q         <= 16'd0;
      word_cnt_q    <= 16'd0;
      byte_cnt_q    <= 2'd0;
      asm_q         <= 32'd0;
      csum_q        <= 8'd0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= 32'd0;
      imem_wdata_q  <= 32'd0;
      cpu_n_reset_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      csum_q        <= csum_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rx_ready_q    <= rx_ready_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed streams plus random programs with random
// rx_valid gaps, scored against expected memory writes and final status.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_n_reset;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];     // expected {addr, data} memory writes, in order
  logic [7:0]  stream_q[$];  // bytes to send
  logic [31:0] prog_w[$];    // program words for random tests

  prog_loader #(.MAX_WORDS(1024), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_n_reset(cpu_n_reset), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL imem_write unexpected addr=%h data=%h expected none", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL imem_write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver: optional idle gap, then offer one byte until rx_ready is seen
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waited = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout got rx_ready=%b expected 1", rx_ready);
    end
  endtask

  // drive all of stream_q; returns on the negedge after the last transfer
  task automatic send_stream(input int max_gap);
    foreach (stream_q[i]) send_byte(stream_q[i], $urandom_range(0, max_gap));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // reference model: stream and expected writes from a list of words
  task automatic build_stream(input logic bad_csum);
    logic [7:0] cs;
    int n;
    n = prog_w.size();
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        stream_q.push_back(8'(prog_w[k] >> (8 * j)));
        cs = cs ^ 8'(prog_w[k] >> (8 * j));
      end
      exp_q.push_back({32'(4 * k), prog_w[k]});
    end
    stream_q.push_back(bad_csum ? (cs ^ 8'h5A) : cs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready} !== 70'd0) begin
      errors++;
      $display("FAIL reset_values got we=%b addr=%h data=%h nrst=%b done=%b err=%b rdy=%b expected all 0",
               imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || cpu_n_reset !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset got rdy=%b nrst=%b expected 1 0", rx_ready, cpu_n_reset);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB3, 8'h80, 8'h10, 8'h00, 8'h30};
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h001080B3});
    send_stream(0);
    checks++;
    if (done !== 1'b1 || cpu_n_reset !== 1'b1 || err !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run got done=%b nrst=%b err=%b rdy=%b expected 1 1 0 0",
               done, cpu_n_reset, err, rx_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_writes got missing=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_run_ignore();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      checks++;
      if (rx_ready !== 1'b0 || done !== 1'b1 || cpu_n_reset !== 1'b1) begin
        errors++;
        $display("FAIL run_ignore got rdy=%b done=%b nrst=%b expected 0 1 1", rx_ready, done, cpu_n_reset);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset_from_run();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready} !== 70'd0) begin
      errors++;
      $display("FAIL reset_from_run got we=%b addr=%h data=%h nrst=%b done=%b err=%b rdy=%b expected all 0",
               imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_bad_csum();
    apply_reset();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB3, 8'h80, 8'h10, 8'h00, 8'h31};
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h001080B3});
    send_stream(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || cpu_n_reset !== 1'b0 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_csum cycle %0d got err=%b done=%b nrst=%b rdy=%b expected 1 0 0 0",
                 i, err, done, cpu_n_reset, rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    rx_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_csum_writes got missing=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    apply_reset();
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(2);
    checks++;
    if (done !== 1'b1 || cpu_n_reset !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got done=%b nrst=%b err=%b expected 1 1 0", done, cpu_n_reset, err);
    end
  endtask

  task automatic test_too_long();
    apply_reset();
    stream_q = '{8'h01, 8'h04};
    send_stream(0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_n_reset !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL too_long got err=%b done=%b nrst=%b rdy=%b expected 1 0 0 0",
               err, done, cpu_n_reset, rx_ready);
    end
    // exactly MAX_WORDS is still accepted as a length
    apply_reset();
    stream_q = '{8'h00, 8'h04};
    send_stream(0);
    checks++;
    if (err !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL max_len got err=%b rdy=%b expected 0 1", err, rx_ready);
    end
  endtask

  task automatic test_reset_midload();
    apply_reset();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3};
    exp_q.push_back({32'h0, 32'h00000013});
    send_stream(0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready} !== 70'd0) begin
        errors++;
        $display("FAIL midload_reset got we=%b addr=%h data=%h nrst=%b done=%b err=%b rdy=%b expected all 0",
                 imem_we, imem_addr, imem_wdata, cpu_n_reset, done, err, rx_ready);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'hB3, 8'h80, 8'h10, 8'h00, 8'h30};
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h001080B3});
    send_stream(4);
    checks++;
    if (done !== 1'b1 || cpu_n_reset !== 1'b1 || err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midload_replay got done=%b nrst=%b err=%b missing=%0d expected 1 1 0 0",
               done, cpu_n_reset, err, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic bad;
      int n;
      apply_reset();
      n = $urandom_range(0, 6);
      bad = ($urandom_range(0, 2) == 0);
      prog_w.delete();
      for (int k = 0; k < n; k++) prog_w.push_back($urandom);
      build_stream(bad);
      send_stream(3);
      checks++;
      if (done !== !bad || err !== bad || cpu_n_reset !== !bad || rx_ready !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random it=%0d n=%0d got done=%b err=%b nrst=%b rdy=%b missing=%0d expected done=%b err=%b",
                 it, n, done, err, cpu_n_reset, rx_ready, exp_q.size(), !bad, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_run_ignore();
    test_reset_from_run();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_reset_midload();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
